// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the EX-stage multiply/divide unit: the encodings of
// the mult/div operation field decoded in ID and the unit's FSM states.
// No ports; imported by the unit, its sub-module and its testbench.
package mips_pkg;

    // Encoding of the 2-bit op field; bit 1 selects divide, bit 0 unsigned.
    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } mdOp_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_FIX
    } mdState_t;

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if
// Bundles the ID/EX-side request signals and the HI/LO/stall results of the
// multiply/divide unit.
//   master: pipeline side, drives start/op/operands/moves/mf_req/kill and
//           reads hi/lo/busy/stall_req.
//   slave : the unit itself.
interface ex_muldiv_if #(parameter int WIDTH = 32);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             mthi;
    logic             mtlo;
    logic             mf_req;
    logic             kill;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall_req;

    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo, mf_req, kill,
        input  hi, lo, busy, stall_req
    );

    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo, mf_req, kill,
        output hi, lo, busy, stall_req
    );

endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter
// Per-cycle datapath of the iterative multiply/divide unit. Holds a
// 2*WIDTH accumulator split into accHi/accLo plus the operand that is added
// (multiplicand) or subtracted (divisor) on every step.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   load         capture magnitudes aIn/bIn and clear the upper accumulator
//   step         perform one shift-add (multiply) or restoring step (divide)
//   isDiv        selects divide behaviour for load and step
//   aIn, bIn     operand magnitudes (multiplicand/dividend, multiplier/divisor)
//   accHi, accLo product halves, or remainder / quotient for divides
module muldiv_iter #(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             isDiv,
    input  logic [WIDTH-1:0] aIn,
    input  logic [WIDTH-1:0] bIn,
    output logic [WIDTH-1:0] accHi,
    output logic [WIDTH-1:0] accLo
);

    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH-1:0] divDiff;
    logic             divFits;

    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then the whole accumulator shifts right by one.
    // Divide: shift remainder:dividend left by one and trial-subtract the
    // divisor. The shifted remainder can need WIDTH+1 bits, so the fit test is
    // done at that width; a divisor of zero always fits, which naturally
    // yields an all-ones quotient and the dividend as remainder.
    always_comb begin
        mulSum   = {1'b0, hiReg} + (loReg[0] ? {1'b0, addend} : '0);
        divShift = {hiReg, loReg[WIDTH-1]};
        divFits  = (divShift >= {1'b0, addend});
        divDiff  = divShift[WIDTH-1:0] - addend;
    end

    // On load the multiplier (or dividend) sits in the low half so that its
    // bits are consumed from the bottom (or top) as the accumulator shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            hiReg  <= '0;
            loReg  <= '0;
            addend <= '0;
        end else if (load) begin
            hiReg  <= '0;
            loReg  <= isDiv ? aIn : bIn;
            addend <= isDiv ? bIn : aIn;
        end else if (step) begin
            if (isDiv) begin
                hiReg <= divFits ? divDiff : divShift[WIDTH-1:0];
                loReg <= {loReg[WIDTH-2:0], divFits};
            end else begin
                hiReg <= mulSum[WIDTH:1];
                loReg <= {mulSum[0], loReg[WIDTH-1:1]};
            end
        end
    end

    assign accHi = hiReg;
    assign accLo = loReg;

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv
// Iterative MULT/MULTU/DIV/DIVU unit of the EX stage. Owns HI/LO, runs one
// iteration per cycle for WIDTH cycles, then applies signs in a final FIX
// cycle. Raises stall_req toward the hazard unit while it is busy and the
// instruction in EX needs it.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       ex_muldiv_if slave: start/op/rs_data/rt_data/mthi/mtlo/mf_req/
//             kill in, hi/lo/busy/stall_req out
module ex_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mdState_t         state, nextState;
    logic [CNT_W-1:0] count;
    mdOp_t            opReg;
    mdOp_t            opIn;
    logic             signA, signB, bZero;
    logic             launch, step, fixWrite;
    logic             signedIn, aNeg, bNeg, iterIsDiv;
    logic [WIDTH-1:0] absA, absB;
    logic [WIDTH-1:0] accHi, accLo;
    logic [WIDTH-1:0] hiReg, loReg;
    logic [WIDTH-1:0] resHi, resLo;
    logic [2*WIDTH-1:0] product;

    // Operand magnitudes for the unsigned datapath; unsigned ops pass through.
    always_comb begin
        opIn     = mdOp_t'(bus.op);
        signedIn = (opIn == MD_MULT) || (opIn == MD_DIV);
        aNeg     = signedIn & bus.rs_data[WIDTH-1];
        bNeg     = signedIn & bus.rt_data[WIDTH-1];
        absA     = aNeg ? -bus.rs_data : bus.rs_data;
        absB     = bNeg ? -bus.rt_data : bus.rt_data;
    end

    // While idle the datapath must load with the incoming op's layout;
    // afterwards it follows the latched op.
    assign iterIsDiv = (state == MD_IDLE) ? opIn[1] : opReg[1];

    muldiv_iter #(.WIDTH(WIDTH)) iter (
        .clk   (clk),
        .rst   (rst),
        .load  (launch),
        .step  (step),
        .isDiv (iterIsDiv),
        .aIn   (absA),
        .bIn   (absB),
        .accHi (accHi),
        .accLo (accLo)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else     state <= nextState;
    end

    // Next-state and control strobes. kill beats start in IDLE and aborts
    // RUN/FIX without touching HI/LO.
    always_comb begin
        nextState = state;
        launch    = 1'b0;
        step      = 1'b0;
        fixWrite  = 1'b0;
        case (state)
            MD_IDLE: begin
                if (bus.start && !bus.kill) begin
                    launch    = 1'b1;
                    nextState = MD_RUN;
                end
            end
            MD_RUN: begin
                step = 1'b1;
                if (bus.kill)                nextState = MD_IDLE;
                else if (count == LAST_ITER) nextState = MD_FIX;
            end
            MD_FIX: begin
                fixWrite  = !bus.kill;
                nextState = MD_IDLE;
            end
            default: nextState = MD_IDLE;
        endcase
    end

    // Sign fix-up. A zero divisor keeps the all-ones quotient even for a
    // negative signed dividend; the remainder always follows the dividend.
    always_comb begin
        product = {accHi, accLo};
        resHi   = accHi;
        resLo   = accLo;
        case (opReg)
            MD_MULT: begin
                if (signA ^ signB) product = -product;
                resHi = product[2*WIDTH-1:WIDTH];
                resLo = product[WIDTH-1:0];
            end
            MD_DIV: begin
                resLo = ((signA ^ signB) && !bZero) ? -accLo : accLo;
                resHi = signA ? -accHi : accHi;
            end
            default: begin
                resHi = product[2*WIDTH-1:WIDTH];
                resLo = product[WIDTH-1:0];
            end
        endcase
    end

    // Operation bookkeeping and the architectural HI/LO. Moves are only
    // honoured while idle, where they may share the edge with a launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            opReg <= MD_MULT;
            signA <= 1'b0;
            signB <= 1'b0;
            bZero <= 1'b0;
            hiReg <= '0;
            loReg <= '0;
        end else begin
            if (launch) begin
                count <= '0;
                opReg <= opIn;
                signA <= aNeg;
                signB <= bNeg;
                bZero <= (bus.rt_data == '0);
            end else if (step) begin
                count <= count + 1'b1;
            end

            if (fixWrite) begin
                hiReg <= resHi;
                loReg <= resLo;
            end else if (state == MD_IDLE) begin
                if (bus.mthi) hiReg <= bus.rs_data;
                if (bus.mtlo) loReg <= bus.rs_data;
            end
        end
    end

    assign bus.hi        = hiReg;
    assign bus.lo        = loReg;
    assign bus.busy      = (state != MD_IDLE);
    assign bus.stall_req = bus.busy & (bus.start | bus.mf_req | bus.mthi | bus.mtlo);

endmodule
